// File: rtl/vga_sync_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster timing for the VGA sync generator and its consumers.
//   - default horizontal/vertical display, porch and sync widths (640x480@60)
//   - derived totals H_TOTAL (800) and V_TOTAL (525)
//   - 10-bit coordinate width and the coordinate type
//   - packed struct holding the registered video_on/hsync/vsync decode
//   - helper functions for the sync/blanking decode
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Coordinate width: both totals must stay below 2**COORD_W.
  localparam int COORD_W = 10;

  // Horizontal timing (pixels)
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Vertical timing (lines)
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // System clocks per pixel (100 MHz -> 25 MHz)
  localparam int DEF_PIX_DIV   = 4;

  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Width of the optional frame counter.
  localparam int FRAME_CNT_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  // Registered blanking/sync decode. Syncs are active-low.
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_RESET = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Inclusive unsigned range test.
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Decode blanking and sync for one coordinate pair.
  function automatic sync_t decode_sync(
    coord_t x, coord_t y,
    coord_t h_disp, coord_t hs_first, coord_t hs_last,
    coord_t v_disp, coord_t vs_first, coord_t vs_last
  );
    sync_t s;
    s.video_on = (x < h_disp) && (y < v_disp);
    s.hsync    = !in_range(x, hs_first, hs_last);
    s.vsync    = !in_range(y, vs_first, vs_last);
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// -----------------------------------------------------------------------------
// vga_sync_if
// Raster timing bundle from the sync generator to the renderer / pin stage.
//   p_tick     : pixel enable, one clk wide every PIX_DIV clks
//   pixl_x     : horizontal count
//   pixl_y     : vertical count
//   video_on   : high inside the visible area
//   hsync      : active-low horizontal sync
//   vsync      : active-low vertical sync
//   frame_tick : one-clk pulse when the counts return to (0,0)
// Flow control: there is no valid/ready pair. The generator free-runs and the
// consumer can never stall it; p_tick acts as a valid-only qualifier marking
// the single clk in which each coordinate pair is about to advance.
// Modports: master drives (vga_sync), slave observes (renderer / pins).
// -----------------------------------------------------------------------------
interface vga_sync_if;

  logic                   p_tick;
  vga_timing_pkg::coord_t pixl_x;
  vga_timing_pkg::coord_t pixl_y;
  logic                   video_on;
  logic                   hsync;
  logic                   vsync;
  logic                   frame_tick;

  modport master (
    output p_tick,
    output pixl_x,
    output pixl_y,
    output video_on,
    output hsync,
    output vsync,
    output frame_tick
  );

  modport slave (
    input p_tick,
    input pixl_x,
    input pixl_y,
    input video_on,
    input hsync,
    input vsync,
    input frame_tick
  );

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock by PIX_DIV and produces a registered one-clk pixel
// enable. The divider counts 0..PIX_DIV-1 from reset; p_tick is high during
// the clk in which the divider holds PIX_DIV-1, so the first tick appears in
// the PIX_DIV-th clk after reset release. PIX_DIV must be >= 2.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   p_tick : pixel enable
// -----------------------------------------------------------------------------
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int              DIV_W    = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_nxt = '0;
    end
  end

  // p_tick is registered from the next divider value so it is high exactly
  // while div_q == DIV_LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      p_tick <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      p_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
// Raster timing generator for a 640x480@60 Hz display (800x525 total) running
// from the 100 MHz board clock with a divided pixel enable.
// Ports:
//   clk       : system clock, 100 MHz
//   reset     : asynchronous active-low reset
//   vga       : vga_sync_if.master (p_tick, pixl_x, pixl_y, video_on, hsync,
//               vsync, frame_tick), all outputs registered
//   frame_cnt : 8-bit frame counter, present only when VGA_FRAME_CNT_EN is
//               defined; increments with each frame_tick and wraps 255->0
// Build option: VGA_FRAME_CNT_EN adds frame_cnt; without it there is no port
// and no counter.
// Timing: counts advance on the edge after a p_tick clk. video_on, hsync and
// vsync are decoded from the next-state counts and registered, so they change
// on the same edge as pixl_x/pixl_y. Every coordinate pair is held for PIX_DIV
// clks; consumers needing one pulse per pixel must qualify with p_tick.
// -----------------------------------------------------------------------------
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIX_DIV   = DEF_PIX_DIV
) (
  input  logic              clk,
  input  logic              reset,
  vga_sync_if.master        vga
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_DISP   = coord_t'(H_DISPLAY);
  localparam coord_t V_DISP   = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   p_tick;
  coord_t pixl_x_q;
  coord_t pixl_y_q;
  coord_t x_nxt;
  coord_t y_nxt;
  logic   frame_wrap;
  sync_t  sync_q;
  sync_t  sync_nxt;
  logic   frame_tick_q;

  pixel_tick_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Next-state counts. frame_wrap marks the edge on which (H_LAST, V_LAST)
  // rolls over to (0,0); it is registered into frame_tick, so reset alone
  // never produces a frame_tick.
  always_comb begin
    x_nxt      = pixl_x_q;
    y_nxt      = pixl_y_q;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (pixl_x_q == H_LAST) begin
        x_nxt = '0;
        if (pixl_y_q == V_LAST) begin
          y_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          y_nxt = pixl_y_q + coord_t'(1);
        end
      end else begin
        x_nxt = pixl_x_q + coord_t'(1);
      end
    end
  end

  // Decoding the next-state counts keeps the syncs aligned with the
  // coordinates they describe.
  always_comb begin
    sync_nxt = decode_sync(x_nxt, y_nxt,
                           H_DISP, HS_FIRST, HS_LAST,
                           V_DISP, VS_FIRST, VS_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixl_x_q     <= '0;
      pixl_y_q     <= '0;
      sync_q       <= SYNC_RESET;
      frame_tick_q <= 1'b0;
    end else begin
      pixl_x_q     <= x_nxt;
      pixl_y_q     <= y_nxt;
      sync_q       <= sync_nxt;
      frame_tick_q <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts in step with frame_tick: the value seen while frame_tick is high
  // already includes that frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end
`endif

  assign vga.p_tick     = p_tick;
  assign vga.pixl_x     = pixl_x_q;
  assign vga.pixl_y     = pixl_y_q;
  assign vga.video_on   = sync_q.video_on;
  assign vga.hsync      = sync_q.hsync;
  assign vga.vsync      = sync_q.vsync;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync
// Two generators share clock and reset: u_dut_a with the full 640x480 timing
// (PIX_DIV=4) and u_dut_b with a tiny 12x8 raster (PIX_DIV=2) so complete
// frames fit in a short run. Every clk after reset release both are compared
// against a closed-form raster position computed from the number of edges
// since release; directed checks cover the reset values, first p_tick, line
// and frame lengths, sync windows, mid-frame reset and (with
// VGA_FRAME_CNT_EN) the frame counter wrap.
// Small raster: H 7/1/2/2 (total 12, hsync low x=8..9),
//               V 4/1/2/1 (total 8, vsync low y=5..6), 192 clks per frame.
// -----------------------------------------------------------------------------
module tb_vga_sync;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
    logic [7:0] fcnt;
  } obs_t;

  localparam obs_t RST_OBS = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, video_on: 1'b0,
                               hsync: 1'b1, vsync: 1'b1, frame_tick: 1'b0,
                               fcnt: 8'd0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  vga_sync_if vga_a ();
  vga_sync_if vga_b ();

  logic [7:0] fcnt_a;
  logic [7:0] fcnt_b;

  vga_sync u_dut_a (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_a)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (fcnt_a)
`endif
  );

  vga_sync #(
    .H_DISPLAY (7),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (2),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1),
    .PIX_DIV   (2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_b)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (fcnt_b)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fcnt_a = 8'd0;
  assign fcnt_b = 8'd0;
`endif

  obs_t obs_a;
  obs_t obs_b;

  assign obs_a = {vga_a.p_tick, vga_a.pixl_x, vga_a.pixl_y, vga_a.video_on,
                  vga_a.hsync, vga_a.vsync, vga_a.frame_tick, fcnt_a};
  assign obs_b = {vga_b.p_tick, vga_b.pixl_x, vga_b.pixl_y, vga_b.video_on,
                  vga_b.hsync, vga_b.vsync, vga_b.frame_tick, fcnt_b};

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after the n-th clk edge following reset release.
  function automatic obs_t expect_at(input int n, input int div,
                                     input int hd, input int hf, input int hs, input int hb,
                                     input int vd, input int vf, input int vs, input int vb);
    obs_t e;
    int   ht;
    int   vt;
    int   p;
    int   x;
    int   y;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = n / div;
    x  = p % ht;
    y  = (p / ht) % vt;
    e.p_tick     = ((n % div) == (div - 1));
    e.x          = 10'(x);
    e.y          = 10'(y);
    e.video_on   = (x < hd) && (y < vd);
    e.hsync      = !((x >= hd + hf) && (x < hd + hf + hs));
    e.vsync      = !((y >= vd + vf) && (y < vd + vf + vs));
    e.frame_tick = ((n % div) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
`ifdef VGA_FRAME_CNT_EN
    e.fcnt       = 8'((p / (ht * vt)) % 256);
`else
    e.fcnt       = 8'd0;
`endif
    return e;
  endfunction

  // ---------------- per-clk monitor state ----------------
  int n_rel;
  int a_err;
  int b_err;
  int a_ticks_l1;
  int a_hs_low_l1;
  int a_hs_first;
  int a_hs_last;
  int a_vid_l1;
  int a_vid_bad;
  int b_ft_cnt;
  int b_ft_first;
  int b_ft_last;
  int b_gap_bad;
  int b_vs_low_f1;
  int b_vid_f1;
  int b_vid_bad;

  task automatic clear_stats();
    a_ticks_l1  = 0;
    a_hs_low_l1 = 0;
    a_hs_first  = -1;
    a_hs_last   = -1;
    a_vid_l1    = 0;
    a_vid_bad   = 0;
    b_ft_cnt    = 0;
    b_ft_first  = -1;
    b_ft_last   = -1;
    b_gap_bad   = 0;
    b_vs_low_f1 = 0;
    b_vid_f1    = 0;
    b_vid_bad   = 0;
  endtask

  // Advance nclk edges, sampling 1 time unit after each rising edge.
  task automatic scan(input int nclk);
    obs_t ea;
    obs_t eb;
    for (int i = 0; i < nclk; i++) begin
      @(posedge clk);
      #1;
      n_rel++;
      ea = expect_at(n_rel, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = expect_at(n_rel, 2, 7, 1, 2, 2, 4, 1, 2, 1);
      if (obs_a !== ea) a_err++;
      if (obs_b !== eb) b_err++;
      // full raster: statistics over line 1 (line 0 loses its first clk to reset)
      if (obs_a.y == 10'd1) begin
        if (obs_a.p_tick) a_ticks_l1++;
        if (obs_a.video_on) a_vid_l1++;
        if (!obs_a.hsync) begin
          a_hs_low_l1++;
          if (a_hs_first < 0) a_hs_first = int'(obs_a.x);
          a_hs_last = int'(obs_a.x);
        end
      end
      if (obs_a.video_on && (obs_a.x >= 10'd640 || obs_a.y >= 10'd480)) a_vid_bad++;
      // small raster: frame spacing and statistics over frame 1
      if (obs_b.frame_tick) begin
        if (b_ft_last >= 0 && (n_rel - b_ft_last) != 192) b_gap_bad++;
        if (b_ft_first < 0) b_ft_first = n_rel;
        b_ft_last = n_rel;
        b_ft_cnt++;
      end
      if (b_ft_cnt == 1) begin
        if (!obs_b.vsync) b_vs_low_f1++;
        if (obs_b.video_on) b_vid_f1++;
      end
      if (obs_b.video_on && (obs_b.x >= 10'd7 || obs_b.y >= 10'd4)) b_vid_bad++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    n_checks = 0;
    n_pass   = 0;
    n_rel    = 0;
    a_err    = 0;
    b_err    = 0;
    clear_stats();

    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_vals_a", obs_a, RST_OBS);
    check("rst_vals_b", obs_b, RST_OBS);

    @(negedge clk);
    reset = 1'b1;

    scan(1);
    check("a_video_on_first_edge", vga_a.video_on, 1);
    check("a_x_first_edge", vga_a.pixl_x, 0);
    check("b_ptick_first_edge", vga_b.p_tick, 1);
    scan(1);
    check("a_ptick_clk2", vga_a.p_tick, 0);
    check("b_x_after_tick", vga_b.pixl_x, 1);
    scan(1);
    check("a_first_ptick_clk4", vga_a.p_tick, 1);
    check("a_x_during_tick", vga_a.pixl_x, 0);
    scan(1);
    check("a_x_after_tick", vga_a.pixl_x, 1);
    check("a_ptick_after_tick", vga_a.p_tick, 0);

    scan(6500);
    check("a_pticks_per_line", a_ticks_l1, 800);
    check("a_hsync_low_clks", a_hs_low_l1, 384);
    check("a_hsync_first_x", a_hs_first, 656);
    check("a_hsync_last_x", a_hs_last, 751);
    check("a_video_clks_line", a_vid_l1, 2560);
    check("a_video_outside", a_vid_bad, 0);
    check("b_first_frame_tick", b_ft_first, 192);
    check("b_frame_ticks", b_ft_cnt, 33);
    check("b_frame_gap", b_gap_bad, 0);
    check("b_vsync_low_clks", b_vs_low_f1, 48);
    check("b_video_clks_frame", b_vid_f1, 56);
    check("b_video_outside", b_vid_bad, 0);

    // Mid-line reset on the full raster.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      scan(1);
      if (vga_a.pixl_x == 10'd300) found = 1'b1;
    end
    check("a_reach_x300", vga_a.pixl_x, 300);
    check("a_reach_y2", vga_a.pixl_y, 2);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_a", obs_a, RST_OBS);
    check("midrst_b", obs_b, RST_OBS);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_hold_a", obs_a, RST_OBS);
    @(negedge clk);
    reset = 1'b1;
    n_rel = 0;
    clear_stats();

    scan(4);
    check("restart_x", vga_a.pixl_x, 1);
    check("restart_y", vga_a.pixl_y, 0);
    scan(400);
    check("restart_b_frame_ticks", b_ft_cnt, 2);

`ifdef VGA_FRAME_CNT_EN
    scan(257 * 192 - n_rel);
    check("b_frame_cnt_wrap", fcnt_b, 1);
    check("b_frame_ticks_257", b_ft_cnt, 257);
    check("a_frame_cnt", fcnt_a, 0);
`endif

    check("a_model_errs", a_err, 0);
    check("b_model_errs", b_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Timing generator that produces the pixel coordinates, `video_on` and sync pulses consumed by the pong renderer and the VGA pins.
- Derives a 25 MHz pixel enable from the 100 MHz system clock.
- Scans a 640x480@60 Hz raster (800x525 total).
- Sits between the board clock and the pong renderer/RGB output stage.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 4, clk cycles per pixel (must be >=2)

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- p_tick  output  1  pixel enable; one clk wide, every PIX_DIV clks
- pixl_x  output  10  horizontal count, 0..799
- pixl_y  output  10  vertical count, 0..524
- video_on  output  1  high while pixl_x<H_DISPLAY and pixl_y<V_DISPLAY
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- frame_tick  output  1  one-clk pulse at start of each frame

Behaviour:
- Only one clock. All state sits in flops with an async active-low reset. Every output is registered.
- Reset values: p_tick=0, pixl_x=0, pixl_y=0, video_on=0, hsync=1, vsync=1, frame_tick=0, divider=0.
- Divider:
  - Counts 0..PIX_DIV-1, then wraps.
  - p_tick is high in the clk cycle where the divider equals PIX_DIV-1.
  - First p_tick comes PIX_DIV clks after reset release.
- Horizontal counter:
  - Advances only on p_tick.
  - Wraps from H_TOTAL-1 (799) to 0, where H_TOTAL = sum of the H params.
- Vertical counter:
  - Advances only on p_tick when the horizontal counter wraps.
  - Wraps from V_TOTAL-1 (524) to 0.
- Output derivation:
  - hsync, vsync and video_on are registered decodes of the next-state counts, so all outputs change on the same edge as pixl_x/pixl_y. Zero skew between coordinates and syncs.
  - video_on first goes high on the first clk edge after reset release (counts are (0,0)).
- hsync=0 while H_DISPLAY+H_FRONT <= pixl_x <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751.
- vsync=0 while V_DISPLAY+V_FRONT <= pixl_y <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491.
- frame_tick is high for exactly one clk: the cycle in which the counts first read (0,0) after a wrap from (799,524). It is not asserted by reset alone.
- Each coordinate pair (pixl_x, pixl_y) is held for PIX_DIV clks. Downstream per-clk detectors such as x==0 && y==481 therefore see PIX_DIV consecutive clks per frame. This is intentional; consumers must qualify with p_tick if they need a single pulse.
- Reset asserted mid-frame: all state returns to reset values immediately. After release the scan restarts at (0,0) with no partial-line output.
- Widths: counters are 10 bits, sized for V_TOTAL/H_TOTAL < 1024. Compare arithmetic is unsigned.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt, 8 bits.
  - Reset value 0.
  - Increments on every frame_tick and wraps 255->0.
  - Intended for blink/animation rate control.
- Undefined: port absent, no counter logic.
- All other behaviour is identical in both builds.

Decomposition:
- Package vga_timing_pkg holds:
  - default H/V porch/sync/display constants
  - derived H_TOTAL=800 and V_TOTAL=525
  - the 10-bit coordinate width constant
- One sub-module, pixel_tick_gen:
  - the PIX_DIV divider producing p_tick
  - its own async active-low reset
- Counters and sync decode stay in vga_sync.

Test Plan:
- Reset held low for 10 clks then released -> all outputs at reset values during reset; video_on=1 one clk after release; first p_tick at clk 4; pixl_x=1 on the clk after that p_tick.
- Free-run one line -> exactly 800 p_ticks per line; hsync low for 96 p_ticks (384 clks) starting when pixl_x becomes 656; pixl_x returns to 0 after 799.
- Free-run one frame -> 420000 p_ticks (1,680,000 clks) between frame_ticks; vsync low for 2 lines (1600 p_ticks) starting at pixl_y=490.
- Count video_on over one frame -> 307200 p_ticks with video_on=1; video_on=0 whenever pixl_x>=640 or pixl_y>=480.
- Assert reset at pixl_x=300, pixl_y=200 -> within the same clk, counts=0, hsync=vsync=1, video_on=0; after release the scan restarts at (0,0).
- Build with VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt reads 1 (wrapped after 255); without the macro the netlist has no frame_cnt port.
